// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer scan-out definitions: word packing, C64 window size and the
// fixed 16-colour C64 palette (also used by the framebuffer write side).
package fb_scanout_pkg;

    localparam int FB_PIX_PER_WORD = 4;
    localparam int FB_IDX_W        = 4;
    localparam int FB_WORD_W       = 16;
    localparam int RGB_W           = 24;

    localparam int C64_SCREEN_W    = 504;
    localparam int C64_SCREEN_H    = 312;

    // Borders that centre the C64 screen inside a 640x480 VGA frame.
    localparam int C64_HBORDER     = (640 - C64_SCREEN_W) / 2;
    localparam int C64_VBORDER     = (480 - C64_SCREEN_H) / 2;

    localparam logic [RGB_W-1:0] C64_PALETTE [16] = '{
        24'h000000, 24'hffffff, 24'h880000, 24'haaffee,
        24'hcc44cc, 24'h00cc55, 24'h0000aa, 24'heeee77,
        24'hdd8855, 24'h664400, 24'hff7777, 24'h333333,
        24'h777777, 24'haaff66, 24'h0088ff, 24'hbbbbbb
    };

endpackage

// File: rtl/c64_palette.sv
// Combinational C64 colour index -> 24-bit {R,G,B} lookup.
module c64_palette
    import fb_scanout_pkg::*;
(
    input  logic [FB_IDX_W-1:0] i_idx,
    output logic [RGB_W-1:0]    o_rgb
);

    assign o_rgb = C64_PALETTE[i_idx];

endmodule

// File: rtl/fb_scanout.sv
// Pixel-clock scan-out: pops packed colour-index words from the read FIFO, unpacks them
// inside the C64 window, maps through the palette. Optional: FB_SCANOUT_UNDERRUN_STATS_EN.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int HBORDER = C64_HBORDER,
    parameter int VBORDER = C64_VBORDER,
    parameter int POS_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [POS_W-1:0]     i_hpos,
    input  logic [POS_W-1:0]     i_vpos,
    input  logic                 i_hsync,
    input  logic                 i_vsync,
    input  logic                 i_blank,
    input  logic                 i_frame_sync,
    input  logic [FB_WORD_W-1:0] i_fifo_rdata,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd,
    output logic                 o_fifo_rst,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_blank,
    output logic [RGB_W-1:0]     o_rgb
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
    ,
    output logic [15:0]          o_underrun_cnt,
    output logic                 o_underrun_flag
`endif
);

    localparam int NIB_W = $clog2(FB_PIX_PER_WORD);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(FB_PIX_PER_WORD - 1);
    localparam logic [POS_W-1:0] H_LO = POS_W'(HBORDER);
    localparam logic [POS_W-1:0] H_HI = POS_W'(640 - HBORDER);
    localparam logic [POS_W-1:0] V_LO = POS_W'(VBORDER);
    localparam logic [POS_W-1:0] V_HI = POS_W'(480 - VBORDER);

    logic                active;
    logic                underrun;
    logic [NIB_W-1:0]    nib_q, nib_d;
    logic                fifo_rst_q, fifo_rst_d;

    logic [FB_IDX_W-1:0] idx_p1_q, idx_p1_d;
    logic                vld_p1_q, vld_p1_d;
    logic                und_p1_q, und_p1_d;
    logic                hsync_p1_q, hsync_p1_d;
    logic                vsync_p1_q, vsync_p1_d;
    logic                blank_p1_q, blank_p1_d;

    logic [RGB_W-1:0]    pal_rgb;
    logic [RGB_W-1:0]    rgb_p2_q, rgb_p2_d;
    logic                hsync_p2_q, hsync_p2_d;
    logic                vsync_p2_q, vsync_p2_d;
    logic                blank_p2_q, blank_p2_d;

    always_comb begin
        active   = (i_hpos > H_LO) && (i_hpos <= H_HI) && (i_vpos > V_LO) && (i_vpos <= V_HI);
        underrun = active & i_fifo_empty;

        // Frame restart realigns to nibble 0 and wins over any increment.
        nib_d = nib_q;
        if (i_frame_sync)
            nib_d = '0;
        else if (active)
            nib_d = nib_q + 1'b1;

        fifo_rst_d = i_frame_sync;

        // Stage 1: select the nibble, register window/underrun/sync state
        idx_p1_d   = i_fifo_rdata[nib_q*FB_IDX_W +: FB_IDX_W];
        vld_p1_d   = active;
        und_p1_d   = underrun;
        hsync_p1_d = i_hsync;
        vsync_p1_d = i_vsync;
        blank_p1_d = i_blank;

        // Stage 2: palette lookup, black outside the window or on underrun
        rgb_p2_d   = (vld_p1_q & ~und_p1_q) ? pal_rgb : '0;
        hsync_p2_d = hsync_p1_q;
        vsync_p2_d = vsync_p1_q;
        blank_p2_d = blank_p1_q;
    end

    // rst gating makes an asynchronous reset cancel a pending pop in the same cycle.
    assign o_fifo_rd = active & (nib_q == NIB_LAST) & ~i_fifo_empty & ~i_frame_sync & ~rst;

    c64_palette u_palette (
        .i_idx (idx_p1_q),
        .o_rgb (pal_rgb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_q      <= '0;
            fifo_rst_q <= 1'b0;
            idx_p1_q   <= '0;
            vld_p1_q   <= 1'b0;
            und_p1_q   <= 1'b0;
            hsync_p1_q <= 1'b0;
            vsync_p1_q <= 1'b0;
            blank_p1_q <= 1'b0;
            rgb_p2_q   <= '0;
            hsync_p2_q <= 1'b0;
            vsync_p2_q <= 1'b0;
            blank_p2_q <= 1'b0;
        end else begin
            nib_q      <= nib_d;
            fifo_rst_q <= fifo_rst_d;
            idx_p1_q   <= idx_p1_d;
            vld_p1_q   <= vld_p1_d;
            und_p1_q   <= und_p1_d;
            hsync_p1_q <= hsync_p1_d;
            vsync_p1_q <= vsync_p1_d;
            blank_p1_q <= blank_p1_d;
            rgb_p2_q   <= rgb_p2_d;
            hsync_p2_q <= hsync_p2_d;
            vsync_p2_q <= vsync_p2_d;
            blank_p2_q <= blank_p2_d;
        end
    end

    assign o_fifo_rst = fifo_rst_q;
    assign o_rgb      = rgb_p2_q;
    assign o_hsync    = hsync_p2_q;
    assign o_vsync    = vsync_p2_q;
    assign o_blank    = blank_p2_q;

`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;
    logic        uflag_q, uflag_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    always_comb begin
        ucnt_d  = underrun ? sat_inc(ucnt_q) : ucnt_q;
        uflag_d = uflag_q | underrun;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q  <= '0;
            uflag_q <= 1'b0;
        end else begin
            ucnt_q  <= ucnt_d;
            uflag_q <= uflag_d;
        end
    end

    assign o_underrun_cnt  = ucnt_q;
    assign o_underrun_flag = uflag_q;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: stimulus pushes expected pipeline outputs, a
// negedge monitor pops and compares them two clocks later.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  i_hpos = '0;
    logic [9:0]  i_vpos = '0;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic        i_blank = 1'b0;
    logic        i_frame_sync = 1'b0;
    logic [15:0] i_fifo_rdata = '0;
    logic        i_fifo_empty = 1'b0;
    logic        o_fifo_rd;
    logic        o_fifo_rst;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_blank;
    logic [23:0] o_rgb;
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
    logic [15:0] o_underrun_cnt;
    logic        o_underrun_flag;
`endif

    fb_scanout dut (
        .clk          (clk),
        .rst          (rst),
        .i_hpos       (i_hpos),
        .i_vpos       (i_vpos),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_blank      (i_blank),
        .i_frame_sync (i_frame_sync),
        .i_fifo_rdata (i_fifo_rdata),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .o_fifo_rst   (o_fifo_rst),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_blank      (o_blank),
        .o_rgb        (o_rgb)
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
        ,
        .o_underrun_cnt  (o_underrun_cnt),
        .o_underrun_flag (o_underrun_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        int          tag;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.tag != cyc || o_rgb !== e.rgb || o_hsync !== e.hs ||
                o_vsync !== e.vs || o_blank !== e.bl) begin
                bad++;
                $display("FAIL %s: got rgb=%h hs=%b vs=%b bl=%b want rgb=%h hs=%b vs=%b bl=%b (cyc %0d tag %0d)",
                         e.nm, o_rgb, o_hsync, o_vsync, o_blank, e.rgb, e.hs, e.vs, e.bl, cyc, e.tag);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [15:0] rd,
                         input logic em, input logic fs, input logic hs, input logic vs,
                         input logic bl, input logic [23:0] exp_rgb, input logic exp_rd,
                         input string nm);
        exp_t e;
        i_hpos       = h;
        i_vpos       = v;
        i_fifo_rdata = rd;
        i_fifo_empty = em;
        i_frame_sync = fs;
        i_hsync      = hs;
        i_vsync      = vs;
        i_blank      = bl;
        e.rgb = exp_rgb;
        e.hs  = hs;
        e.vs  = vs;
        e.bl  = bl;
        e.tag = cyc + 2;
        e.nm  = nm;
        q.push_back(e);
        #1;
        check({nm, "_rd"}, 32'(o_fifo_rd), 32'(exp_rd));
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] h, input logic [15:0] rd, input logic [23:0] exp_rgb,
                       input logic exp_rd, input string nm);
        drive(h, 10'd100, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rgb, exp_rd, nm);
    endtask

    task automatic idle(input string nm);
        drive(10'd0, 10'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0, 1'b0, nm);
    endtask

    initial begin
        // Reset with arbitrary, partly active inputs
        i_hpos = 10'd100; i_vpos = 10'd100; i_fifo_rdata = 16'h10F2;
        i_hsync = 1'b1; i_vsync = 1'b1; i_blank = 1'b1; i_frame_sync = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'(o_rgb), 32'h0);
        check("rst_rd", 32'(o_fifo_rd), 32'h0);
        check("rst_fifo_rst", 32'(o_fifo_rst), 32'h0);
        check("rst_syncs", 32'({o_hsync, o_vsync, o_blank}), 32'h0);
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
        check("rst_ucnt", 32'(o_underrun_cnt), 32'h0);
        check("rst_uflag", 32'(o_underrun_flag), 32'h0);
`endif
        i_frame_sync = 1'b0;
        rst = 1'b0;
        idle("rel0");
        check("rel_hs_1clk", 32'({o_hsync, o_vsync, o_blank}), 32'h0);
        idle("rel1");

        // Main unpack: 10F2 -> 2,F,0,1 then 7654 -> 4,5,6,7
        pix(10'd100, 16'h10F2, 24'h880000, 1'b0, "w0n0");
        pix(10'd101, 16'h10F2, 24'hbbbbbb, 1'b0, "w0n1");
        pix(10'd102, 16'h10F2, 24'h000000, 1'b0, "w0n2");
        pix(10'd103, 16'h10F2, 24'hffffff, 1'b1, "w0n3");
        pix(10'd104, 16'h7654, 24'hcc44cc, 1'b0, "w1n0");
        pix(10'd105, 16'h7654, 24'h00cc55, 1'b0, "w1n1");
        pix(10'd106, 16'h7654, 24'h0000aa, 1'b0, "w1n2");
        pix(10'd107, 16'h7654, 24'heeee77, 1'b1, "w1n3");

        // Window edges
        pix(10'd68,  16'h3333, 24'h000000, 1'b0, "h68");
        pix(10'd69,  16'hDCBA, 24'hff7777, 1'b0, "h69");
        pix(10'd70,  16'hDCBA, 24'h333333, 1'b0, "h70");
        pix(10'd71,  16'hDCBA, 24'h777777, 1'b0, "h71");
        pix(10'd572, 16'hDCBA, 24'haaff66, 1'b1, "h572");
        pix(10'd573, 16'hDCBA, 24'h000000, 1'b0, "h573");
        drive(10'd100, 10'd84,  16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, "v84");
        drive(10'd100, 10'd396, 16'h00E1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hffffff, 1'b0, "v396");
        drive(10'd100, 10'd397, 16'h00E1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, "v397");

        // Underrun for 8 active clocks starting at nibble 1
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
        check("pre_ucnt", 32'(o_underrun_cnt), 32'h0);
`endif
        for (int i = 0; i < 8; i++)
            drive(10'(200 + i), 10'd100, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, "undr");
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
        check("ucnt8", 32'(o_underrun_cnt), 32'd8);
        check("uflag", 32'(o_underrun_flag), 32'h1);
`endif
        pix(10'd210, 16'h4321, 24'h880000, 1'b0, "ur_n1");
        pix(10'd211, 16'h4321, 24'haaffee, 1'b0, "ur_n2");
        pix(10'd212, 16'h4321, 24'hcc44cc, 1'b1, "ur_n3");

        // Frame restart at nibble 2 (outside the window)
        pix(10'd300, 16'h0005, 24'h00cc55, 1'b0, "fs_n0");
        pix(10'd301, 16'h0005, 24'h000000, 1'b0, "fs_n1");
        drive(10'd0, 10'd0, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h0, 1'b0, "fs_pulse");
        check("fifo_rst_hi", 32'(o_fifo_rst), 32'h1);
        pix(10'd302, 16'h0009, 24'h664400, 1'b0, "fs_after");
        check("fifo_rst_lo", 32'(o_fifo_rst), 32'h0);
        // Frame restart beats a pop at nibble 3
        pix(10'd303, 16'hF000, 24'h000000, 1'b0, "fp_n1");
        pix(10'd304, 16'hF000, 24'h000000, 1'b0, "fp_n2");
        drive(10'd305, 10'd100, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hbbbbbb, 1'b0, "fp_n3");
        pix(10'd306, 16'h0002, 24'h880000, 1'b0, "fp_next");

        // Asynchronous reset with a pop pending at nibble 3
        pix(10'd307, 16'h3000, 24'h000000, 1'b0, "ar_n1");
        pix(10'd308, 16'h3000, 24'h000000, 1'b0, "ar_n2");
        idle("ar_idle0");
        idle("ar_idle1");
        repeat (2) @(negedge clk);
        #1;
        i_hpos = 10'd100; i_vpos = 10'd100; i_fifo_rdata = 16'h3000; i_fifo_empty = 1'b0;
        #1;
        check("ar_pend_rd", 32'(o_fifo_rd), 32'h1);
        rst = 1'b1;
        #1;
        check("ar_rd", 32'(o_fifo_rd), 32'h0);
        check("ar_rgb", 32'(o_rgb), 32'h0);
        check("ar_syncs", 32'({o_hsync, o_vsync, o_blank}), 32'h0);
        check("ar_fifo_rst", 32'(o_fifo_rst), 32'h0);
`ifdef FB_SCANOUT_UNDERRUN_STATS_EN
        check("ar_ucnt", 32'(o_underrun_cnt), 32'h0);
        check("ar_uflag", 32'(o_underrun_flag), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix(10'd100, 16'h0006, 24'h0000aa, 1'b0, "ar_nib0");
        idle("end0");
        idle("end1");
        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
